// File: rtl/seg_display_mux_pkg.sv
// seg_display_mux_pkg: character codes, active-low ABCDEFG patterns and scan states
package seg_display_mux_pkg;
    localparam logic [4:0] CH_0     = 5'h00;
    localparam logic [4:0] CH_1     = 5'h01;
    localparam logic [4:0] CH_2     = 5'h02;
    localparam logic [4:0] CH_3     = 5'h03;
    localparam logic [4:0] CH_4     = 5'h04;
    localparam logic [4:0] CH_5     = 5'h05;
    localparam logic [4:0] CH_6     = 5'h06;
    localparam logic [4:0] CH_7     = 5'h07;
    localparam logic [4:0] CH_8     = 5'h08;
    localparam logic [4:0] CH_9     = 5'h09;
    localparam logic [4:0] CH_A     = 5'h0A;
    localparam logic [4:0] CH_B     = 5'h0B;
    localparam logic [4:0] CH_C     = 5'h0C;
    localparam logic [4:0] CH_D     = 5'h0D;
    localparam logic [4:0] CH_E     = 5'h0E;
    localparam logic [4:0] CH_F     = 5'h0F;
    localparam logic [4:0] CH_L     = 5'h10;
    localparam logic [4:0] CH_P     = 5'h11;
    localparam logic [4:0] CH_N     = 5'h12;
    localparam logic [4:0] CH_V     = 5'h13;
    localparam logic [4:0] CH_DASH  = 5'h14;
    localparam logic [4:0] CH_UNDER = 5'h15;
    localparam logic [4:0] CH_BLANK = 5'h16;

    localparam logic [6:0] SEG_0     = 7'b0000001;
    localparam logic [6:0] SEG_1     = 7'b1001111;
    localparam logic [6:0] SEG_2     = 7'b0010010;
    localparam logic [6:0] SEG_3     = 7'b0000110;
    localparam logic [6:0] SEG_4     = 7'b1001100;
    localparam logic [6:0] SEG_5     = 7'b0100100;
    localparam logic [6:0] SEG_6     = 7'b0100000;
    localparam logic [6:0] SEG_7     = 7'b0001111;
    localparam logic [6:0] SEG_8     = 7'b0000000;
    localparam logic [6:0] SEG_9     = 7'b0000100;
    localparam logic [6:0] SEG_A     = 7'b0001000;
    localparam logic [6:0] SEG_B     = 7'b1100000;
    localparam logic [6:0] SEG_C     = 7'b0110001;
    localparam logic [6:0] SEG_D     = 7'b1000010;
    localparam logic [6:0] SEG_E     = 7'b0110000;
    localparam logic [6:0] SEG_F     = 7'b0111000;
    localparam logic [6:0] SEG_L     = 7'b1110001;
    localparam logic [6:0] SEG_P     = 7'b0011000;
    localparam logic [6:0] SEG_N     = 7'b1101010;
    localparam logic [6:0] SEG_V     = 7'b1000001;
    localparam logic [6:0] SEG_DASH  = 7'b1111110;
    localparam logic [6:0] SEG_UNDER = 7'b1110111;
    localparam logic [6:0] SEG_OFF   = 7'b1111111;

    typedef enum logic {ST_GUARD, ST_DRIVE} scan_state_e;
endpackage

// File: rtl/seg_display_mux_if.sv
// seg_display_mux_if: content load port and display pin bundle
interface seg_display_mux_if #(parameter int NUM_DIGITS = 4);
    logic                    load;
    logic [5*NUM_DIGITS-1:0] chars_in;
    logic [NUM_DIGITS-1:0]   dp_in;
    logic [NUM_DIGITS-1:0]   blink_in;
    logic [6:0]              seg_n;
    logic                    dp_n;
    logic [NUM_DIGITS-1:0]   an_n;
    logic                    frame_done;

    modport master (output load, chars_in, dp_in, blink_in, input seg_n, dp_n, an_n, frame_done);
    modport slave  (input load, chars_in, dp_in, blink_in, output seg_n, dp_n, an_n, frame_done);
endinterface

// File: rtl/seg_char_rom.sv
// seg_char_rom: 5-bit character code to active-low ABCDEFG pattern
module seg_char_rom
    import seg_display_mux_pkg::*;
(
    input  logic [4:0] code_i,
    output logic [6:0] seg_o
);
    // Unassigned codes (0x17-0x1F) fall through to blank
    always_comb begin
        seg_o = SEG_OFF;
        case (code_i)
            CH_0:     seg_o = SEG_0;
            CH_1:     seg_o = SEG_1;
            CH_2:     seg_o = SEG_2;
            CH_3:     seg_o = SEG_3;
            CH_4:     seg_o = SEG_4;
            CH_5:     seg_o = SEG_5;
            CH_6:     seg_o = SEG_6;
            CH_7:     seg_o = SEG_7;
            CH_8:     seg_o = SEG_8;
            CH_9:     seg_o = SEG_9;
            CH_A:     seg_o = SEG_A;
            CH_B:     seg_o = SEG_B;
            CH_C:     seg_o = SEG_C;
            CH_D:     seg_o = SEG_D;
            CH_E:     seg_o = SEG_E;
            CH_F:     seg_o = SEG_F;
            CH_L:     seg_o = SEG_L;
            CH_P:     seg_o = SEG_P;
            CH_N:     seg_o = SEG_N;
            CH_V:     seg_o = SEG_V;
            CH_DASH:  seg_o = SEG_DASH;
            CH_UNDER: seg_o = SEG_UNDER;
            default:  seg_o = SEG_OFF;
        endcase
    end
endmodule

// File: rtl/seg_display_mux.sv
// seg_display_mux: multiplexed common-anode 7-segment scanner with guard gaps and
// frame-synchronous content update; optional per-digit blink under SEG_BLINK_EN
module seg_display_mux
    import seg_display_mux_pkg::*;
#(
    parameter int NUM_DIGITS   = 4,
    parameter int DRIVE_CYC    = 50000,
    parameter int GUARD_CYC    = 500,
    parameter int BLINK_FRAMES = 64
) (
    input logic clk,
    input logic rst_n,
    seg_display_mux_if.slave bus
);
    localparam int MAXC = DRIVE_CYC > GUARD_CYC ? DRIVE_CYC : GUARD_CYC;
    localparam int CW = MAXC > 1 ? $clog2(MAXC) : 1;
    localparam int IW = NUM_DIGITS > 1 ? $clog2(NUM_DIGITS) : 1;
    localparam logic [CW-1:0] DRIVE_LAST = CW'(DRIVE_CYC - 1);
    localparam logic [CW-1:0] GUARD_LAST = CW'(GUARD_CYC > 0 ? GUARD_CYC - 1 : 0);
    localparam logic [IW-1:0] IDX_LAST = IW'(NUM_DIGITS - 1);
    // Each digit slot opens with a guard unless the guard is configured away
    localparam scan_state_e ST_SLOT = GUARD_CYC > 0 ? ST_GUARD : ST_DRIVE;
    localparam logic [5*NUM_DIGITS-1:0] ALL_BLANK = {NUM_DIGITS{CH_BLANK}};

    scan_state_e             state_q, state_d;
    logic [CW-1:0]           cnt_q, cnt_d;
    logic [IW-1:0]           idx_q, idx_d;
    logic [5*NUM_DIGITS-1:0] pend_chars_q, shad_chars_q;
    logic [NUM_DIGITS-1:0]   pend_dp_q, pend_blink_q, shad_dp_q, shad_blink_q;
    logic [NUM_DIGITS-1:0]   an_q, an_d;
    logic [6:0]              seg_q, seg_d, rom_seg;
    logic                    dp_q, dp_d, fd_q;
    logic                    guard_end, drive_end, frame_end, hide, blink_phase;

    assign guard_end = state_q == ST_GUARD && cnt_q == GUARD_LAST;
    assign drive_end = state_q == ST_DRIVE && cnt_q == DRIVE_LAST;
    assign frame_end = drive_end && idx_q == IDX_LAST;

    // Slot sequencing: guard -> drive -> next digit, counter cleared on each change
    always_comb begin
        state_d = guard_end ? ST_DRIVE : drive_end ? ST_SLOT : state_q;
        cnt_d   = (guard_end || drive_end) ? '0 : cnt_q + 1'b1;
        idx_d   = frame_end ? '0 : drive_end ? idx_q + 1'b1 : idx_q;
    end

    // Scan state register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_SLOT;
            cnt_q   <= '0;
            idx_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            idx_q   <= idx_d;
        end
    end

    // Pending takes every load; shadow only changes at the frame boundary, with a
    // load on that same cycle bypassing pending so it is not lost for a frame
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pend_chars_q <= ALL_BLANK;
            pend_dp_q    <= '0;
            pend_blink_q <= '0;
            shad_chars_q <= ALL_BLANK;
            shad_dp_q    <= '0;
            shad_blink_q <= '0;
        end else begin
            if (bus.load) begin
                pend_chars_q <= bus.chars_in;
                pend_dp_q    <= bus.dp_in;
                pend_blink_q <= bus.blink_in;
            end
            if (frame_end) begin
                shad_chars_q <= bus.load ? bus.chars_in : pend_chars_q;
                shad_dp_q    <= bus.load ? bus.dp_in : pend_dp_q;
                shad_blink_q <= bus.load ? bus.blink_in : pend_blink_q;
            end
        end
    end

`ifdef SEG_BLINK_EN
    localparam int FW = BLINK_FRAMES > 1 ? $clog2(BLINK_FRAMES) : 1;
    localparam logic [FW-1:0] FRAME_LAST = FW'(BLINK_FRAMES - 1);
    logic [FW-1:0] fcnt_q;
    logic          blink_q;

    // Blink phase flips after every BLINK_FRAMES completed frames
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            fcnt_q  <= '0;
            blink_q <= 1'b0;
        end else if (frame_end) begin
            fcnt_q  <= fcnt_q == FRAME_LAST ? '0 : fcnt_q + 1'b1;
            blink_q <= blink_q ^ (fcnt_q == FRAME_LAST);
        end
    end

    assign blink_phase = blink_q;
`else
    assign blink_phase = 1'b0;
`endif

    seg_char_rom u_rom (
        .code_i (shad_chars_q[5*idx_q +: 5]),
        .seg_o  (rom_seg)
    );

    assign hide = blink_phase & shad_blink_q[idx_q];

    // Pin values for the current slot; anode timing ignores blink
    always_comb begin
        an_d  = state_q == ST_DRIVE ? ~(NUM_DIGITS'(1) << idx_q) : '1;
        seg_d = (state_q == ST_DRIVE && !hide) ? rom_seg : SEG_OFF;
        dp_d  = !(state_q == ST_DRIVE && !hide && shad_dp_q[idx_q]);
    end

    // Registered pins, all dark in reset
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            an_q  <= '1;
            seg_q <= SEG_OFF;
            dp_q  <= 1'b1;
            fd_q  <= 1'b0;
        end else begin
            an_q  <= an_d;
            seg_q <= seg_d;
            dp_q  <= dp_d;
            fd_q  <= frame_end;
        end
    end

    assign bus.an_n       = an_q;
    assign bus.seg_n      = seg_q;
    assign bus.dp_n       = dp_q;
    assign bus.frame_done = fd_q;
endmodule

// File: tb/tb_seg_display_mux.sv
// tb_seg_display_mux: table-driven frame checks plus reset, tear-free, bypass and no-guard sequences
module tb_seg_display_mux;
    localparam int ND = 4;
    localparam int DC = 4;
    localparam int GC = 1;
    localparam int BF = 2;
    localparam int SLOT = GC + DC;
    localparam int FLEN = ND * SLOT;
    localparam logic [6:0] OFF = 7'b1111111;

    typedef struct {
        logic [19:0]     chars;
        logic [3:0]      dp;
        logic [3:0]      blink;
        logic [3:0][6:0] seg;
    } vec_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    seg_display_mux_if #(.NUM_DIGITS(ND)) bus ();
    seg_display_mux_if #(.NUM_DIGITS(ND)) bus0 ();

    assign bus0.load     = bus.load;
    assign bus0.chars_in = bus.chars_in;
    assign bus0.dp_in    = bus.dp_in;
    assign bus0.blink_in = bus.blink_in;

    seg_display_mux #(.NUM_DIGITS(ND), .DRIVE_CYC(DC), .GUARD_CYC(GC), .BLINK_FRAMES(BF)) dut (
        .clk(clk), .rst_n(rst_n), .bus(bus)
    );
    seg_display_mux #(.NUM_DIGITS(ND), .DRIVE_CYC(DC), .GUARD_CYC(0), .BLINK_FRAMES(BF)) dut0 (
        .clk(clk), .rst_n(rst_n), .bus(bus0)
    );

    vec_t tbl [7];
    vec_t blank_v, prev;
    int n_vec = 0;
    int n_err = 0;
    int frame_k = 1;

    task automatic check(input string name, input logic [12:0] act, input logic [12:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: an/seg/dp/fd got %b_%b_%b_%b expected %b_%b_%b_%b", name,
                     act[12:9], act[8:2], act[1], act[0], exp[12:9], exp[8:2], exp[1], exp[0]);
        end
    endtask

    task automatic drive(input vec_t v);
        bus.chars_in = v.chars;
        bus.dp_in    = v.dp;
        bus.blink_in = v.blink;
    endtask

    // Check one full frame starting right after a frame_done cycle; optionally
    // hold load high during cycle ld_o (0 = the frame_done cycle itself)
    task automatic check_frame(input vec_t e, input int ld_o, input vec_t ld);
        logic ph;
        ph = 1'b0;
`ifdef SEG_BLINK_EN
        ph = ((frame_k - 1) / BF) % 2 == 1;
`endif
        if (ld_o == 0) begin
            drive(ld);
            bus.load = 1'b1;
        end
        for (int o = 1; o <= FLEN; o++) begin
            logic [12:0] exp;
            logic hd;
            int k, w;
            @(negedge clk);
            k = (o - 1) / SLOT;
            w = (o - 1) % SLOT;
            hd = ph && e.blink[k];
            if (w < GC) exp = {4'b1111, OFF, 1'b1, o == FLEN};
            else exp = {~(4'b0001 << k), hd ? OFF : e.seg[k], hd | ~e.dp[k], o == FLEN};
            check($sformatf("frame%0d_o%0d", frame_k, o),
                  {bus.an_n, bus.seg_n, bus.dp_n, bus.frame_done}, exp);
            bus.load = (o + 1 == ld_o);
            if (bus.load) drive(ld);
        end
        frame_k++;
    endtask

    initial begin
        blank_v = '{{5{5'h16}} >> 5, 4'b0000, 4'b0000, {4{OFF}}};
        blank_v.chars = {5'h16, 5'h16, 5'h16, 5'h16};
        tbl[0] = '{{5'h03, 5'h02, 5'h01, 5'h00}, 4'b0001, 4'b0000,
                   {7'b0000110, 7'b0010010, 7'b1001111, 7'b0000001}};
        tbl[1] = '{{5'h10, 5'h1F, 5'h1B, 5'h14}, 4'b1010, 4'b0000,
                   {7'b1110001, 7'b1111111, 7'b1111111, 7'b1111110}};
        tbl[2] = '{{5'h0F, 5'h0E, 5'h0D, 5'h0C}, 4'b1111, 4'b0000,
                   {7'b0111000, 7'b0110000, 7'b1000010, 7'b0110001}};
        tbl[3] = '{{5'h0B, 5'h0A, 5'h09, 5'h08}, 4'b0000, 4'b0000,
                   {7'b1100000, 7'b0001000, 7'b0000100, 7'b0000000}};
        tbl[4] = '{{5'h07, 5'h06, 5'h05, 5'h04}, 4'b0110, 4'b0000,
                   {7'b0001111, 7'b0100000, 7'b0100100, 7'b1001100}};
        tbl[5] = '{{5'h13, 5'h12, 5'h11, 5'h15}, 4'b1000, 4'b0000,
                   {7'b1000001, 7'b1101010, 7'b0011000, 7'b1110111}};
        tbl[6] = '{{5'h08, 5'h08, 5'h08, 5'h08}, 4'b0100, 4'b0100,
                   {7'b0000000, 7'b0000000, 7'b0000000, 7'b0000000}};
        bus.load = 1'b0;
        drive(blank_v);

        repeat (3) @(negedge clk);
        check("reset_hold", {bus.an_n, bus.seg_n, bus.dp_n, bus.frame_done}, {4'b1111, OFF, 1'b1, 1'b0});
        rst_n = 1'b1;
        frame_k = 1;
        check_frame(blank_v, -1, blank_v);

        prev = blank_v;
        for (int i = 0; i < 7; i++) begin
            check_frame(prev, 0, tbl[i]);
            prev = tbl[i];
        end
        repeat (4) check_frame(prev, -1, prev);

        check_frame(prev, 7, tbl[0]);
        check_frame(tbl[0], 19, tbl[2]);
        check_frame(tbl[2], -1, tbl[2]);

        begin
            int t;
            t = 0;
            while (bus0.frame_done !== 1'b1 && t < 64) begin
                @(negedge clk);
                t++;
            end
            check("noguard_sync", {12'd0, bus0.frame_done}, 13'd1);
            for (int o = 1; o <= ND * DC; o++) begin
                int k;
                @(negedge clk);
                k = (o - 1) / DC;
                check($sformatf("noguard_o%0d", o), {bus0.an_n, bus0.seg_n, bus0.dp_n, bus0.frame_done},
                      {~(4'b0001 << k), tbl[2].seg[k], ~tbl[2].dp[k], o == ND * DC});
            end
        end

        begin
            int t;
            t = 0;
            while (bus.an_n !== 4'b1011 && t < 64) begin
                @(negedge clk);
                t++;
            end
            check("reach_digit2", {bus.an_n, 9'd0}, {4'b1011, 9'd0});
            @(negedge clk);
            rst_n = 1'b0;
            #1;
            check("reset_async", {bus.an_n, bus.seg_n, bus.dp_n, bus.frame_done}, {4'b1111, OFF, 1'b1, 1'b0});
            repeat (2) @(negedge clk);
            rst_n = 1'b1;
            frame_k = 1;
            check_frame(blank_v, -1, blank_v);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
